// File: rtl/freq_meter_hertz_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_hertz_pkg
//   Shared constants and types for the hertz frequency meter.
//   - BOARD_CLK_FREQ : board system clock in Hz. The hertz divider and the
//                      meter both take their default clock frequency from it.
//   - fm_dbg_t       : FSM observation struct exported by the meter.
//   - gate_cycles()  : gate window length in system clocks.
// ---------------------------------------------------------------------------
package freq_meter_hertz_pkg;

   localparam int unsigned BOARD_CLK_FREQ  = 12_000_000;
   localparam int unsigned DEFAULT_GATE_HZ = 1;
   localparam int          DEFAULT_COUNT_W = 32;

   // measure  : FSM is in the MEASURE state
   // terminal : current cycle is the last cycle of the gate window
   typedef struct packed {
      logic measure;
      logic terminal;
   } fm_dbg_t;

   function automatic int unsigned gate_cycles(input int unsigned clk_freq,
                                               input int unsigned gate_hz);
      return clk_freq / gate_hz;
   endfunction

endpackage : freq_meter_hertz_pkg

// File: rtl/freq_meter_hertz_if.sv
// ---------------------------------------------------------------------------
// freq_meter_hertz_if
//   Result bus of the frequency meter.
//   - freqHz    : last completed measurement in Hz, holds between updates
//   - freqValid : one-cycle strobe, freqHz/overflow were updated this cycle
//   - overflow  : the last result saturated
//   Protocol: there is no back-pressure. freqValid is a pure strobe; the
//   consumer must take freqHz/overflow in the cycle freqValid is high or read
//   the held value later. freqHz and overflow only change when freqValid is 1.
//   Modports: master = meter (drives), slave = consumer (observes).
// ---------------------------------------------------------------------------
interface freq_meter_hertz_if #(
   parameter int COUNT_W = 32
);
   logic [COUNT_W-1:0] freqHz;
   logic               freqValid;
   logic               overflow;

   modport master (output freqHz, output freqValid, output overflow);
   modport slave  (input  freqHz, input  freqValid, input  overflow);

endinterface : freq_meter_hertz_if

// File: rtl/freq_meter_hertz_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   2-FF synchronizer followed by a registered rising-edge detector for an
//   asynchronous external input (signals, buttons, ...).
//   Ports:
//     clk     in  system clock
//     rst     in  asynchronous active-high reset (all flops to 0)
//     sig_i   in  asynchronous input
//     pulse_o out one-clock pulse, 3 clocks after a 0->1 transition of sig_i
// ---------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic pulse_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         // Registered so the pulse is glitch-free for downstream counters.
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule : sync_edge_detect

// File: rtl/freq_meter_hertz.sv
// ---------------------------------------------------------------------------
// freq_meter_hertz
//   Measures the frequency of an asynchronous signal in Hz by counting its
//   rising edges over a gate window of CLK_FREQ/GATE_HZ system clocks and
//   scaling the count by GATE_HZ. A new result is published once per window.
//   Parameters:
//     CLK_FREQ  system clock in Hz (default from BOARD_CLK_FREQ)
//     GATE_HZ   gate windows per second
//     COUNT_W   width of the edge counter and of the result
//   Ports:
//     clk     in  system clock
//     rst     in  asynchronous active-high reset
//     enable  in  measurement runs while high
//     sigIn   in  asynchronous signal under measurement
//     busy    out high while a gate window is in progress
//     dbg     out FSM observation (state, terminal cycle)
//     res     master modport: freqHz / freqValid / overflow
// ---------------------------------------------------------------------------
module freq_meter_hertz
   import freq_meter_hertz_pkg::*;
#(
   parameter int unsigned CLK_FREQ = BOARD_CLK_FREQ,
   parameter int unsigned GATE_HZ  = DEFAULT_GATE_HZ,
   parameter int          COUNT_W  = DEFAULT_COUNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                sigIn,
   output logic                busy,
   output fm_dbg_t             dbg,
   freq_meter_hertz_if.master  res
);

   localparam int unsigned GATE_CYCLES = gate_cycles(CLK_FREQ, GATE_HZ);
   localparam int          GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int          PROD_W      = COUNT_W + 32;
   localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
   localparam logic [GATE_W-1:0]  GATE_END = GATE_W'(GATE_CYCLES - 1);

   if (((CLK_FREQ % GATE_HZ) != 0) || (GATE_CYCLES < 2)) begin : g_bad_cfg
      $error("freq_meter_hertz: CLK_FREQ must be divisible by GATE_HZ and give a window of at least 2 clocks");
   end

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic               edge_sat_q, edge_sat_d;
   logic [COUNT_W-1:0] freq_q, freq_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;

   logic               edge_pulse;
   logic               terminal;
   logic [COUNT_W:0]   edge_sum;
   logic [COUNT_W-1:0] edge_total;
   logic               sum_sat;
   logic [PROD_W-1:0]  prod;
   logic               prod_sat;

   // The synchronizer runs from reset regardless of state, so a level that
   // is already high when enable rises has been absorbed and is not an edge.
   sync_edge_detect u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (sigIn),
      .pulse_o (edge_pulse)
   );

   assign terminal = (state_q == ST_MEASURE) && (gate_cnt_q == GATE_END);

   // Final count includes an edge landing in the terminal cycle; it belongs
   // to the window that is ending, not the next one.
   always_comb begin
      edge_sum   = {1'b0, edge_cnt_q} + {{COUNT_W{1'b0}}, edge_pulse};
      edge_total = edge_sum[COUNT_W] ? CNT_MAX : edge_sum[COUNT_W-1:0];
      sum_sat    = edge_sat_q | edge_sum[COUNT_W];
      prod       = PROD_W'(edge_total) * PROD_W'(GATE_HZ);
      prod_sat   = (prod >> COUNT_W) != '0;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // Both the terminal cycle and an abort leave MEASURE when enable is low,
   // so the transition only depends on enable.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (enable)  state_d = ST_MEASURE;
         ST_MEASURE: if (!enable) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy         = (state_q == ST_MEASURE);
      dbg.measure  = (state_q == ST_MEASURE);
      dbg.terminal = terminal;
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      edge_sat_d = edge_sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;

      if (state_q == ST_MEASURE) begin
         if (terminal) begin
            freq_d     = prod_sat ? CNT_MAX : prod[COUNT_W-1:0];
            ovf_d      = sum_sat | prod_sat;
            valid_d    = 1'b1;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            edge_sat_d = 1'b0;
         end else if (!enable) begin
            // Abort: discard the partial window, keep the last result.
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            edge_sat_d = 1'b0;
         end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            if (edge_pulse) begin
               if (edge_cnt_q == CNT_MAX) begin
                  edge_sat_d = 1'b1;
               end else begin
                  edge_cnt_d = edge_cnt_q + COUNT_W'(1);
               end
            end
         end
      end else begin
         gate_cnt_d = '0;
         edge_cnt_d = '0;
         edge_sat_d = 1'b0;
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         edge_sat_q <= 1'b0;
         freq_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         edge_sat_q <= edge_sat_d;
         freq_q     <= freq_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign res.freqHz    = freq_q;
   assign res.freqValid = valid_q;
   assign res.overflow  = ovf_q;

endmodule : freq_meter_hertz
